// File: rtl/preg_wb_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | preg_wb_sched_pkg : register-file geometry, address types, bank helpers   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package preg_wb_sched_pkg;

  localparam int PKG_WNUM  = 4;
  localparam int PKG_QLEN  = 64;
  localparam int PKG_DEPTH = 4;
  localparam int PREG_W    = $clog2(PKG_QLEN);
  localparam int BANK_W    = $clog2(PKG_WNUM);
  localparam int CNT_W     = $clog2(PKG_DEPTH + 1);

  typedef logic [PREG_W-1:0]        preg_t;
  typedef logic [BANK_W-1:0]        bank_t;
  typedef logic [PREG_W-BANK_W-1:0] bank_off_t;

  function automatic bank_t bank(input preg_t a);
    return bank_t'(a);
  endfunction

  function automatic bank_off_t bank_offset(input preg_t a);
    return bank_off_t'(a >> BANK_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/preg_wb_sched_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_bank_fifo : ordered multi-enqueue FIFO that pops its head every cycle  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module wb_bank_fifo
  import preg_wb_sched_pkg::*;
#(
  parameter int SNUM  = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SNUM-1:0]            i_enq,
  input  logic [SNUM-1:0][AW-1:0]    i_addr,
  input  logic [SNUM-1:0][DW-1:0]    i_data,
  output logic                       o_valid,
  output logic [AW-1:0]              o_addr,
  output logic [DW-1:0]              o_data,
  output logic [CW-1:0]              o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [CW-1:0]           r_count;
  logic [AW-1:0]           r_addr [DEPTH];
  logic [DW-1:0]           r_data [DEPTH];
  logic [PW-1:0]           w_tail_nxt;
  logic [CW-1:0]           w_count_nxt;
  logic [SNUM-1:0][PW-1:0] w_slot;
  logic                    w_pop;

  // DEPTH need not be a power of two, so wrap by compare rather than overflow
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    logic [PW-1:0] ptr;
    int            n;
    ptr   = r_tail;
    n     = 0;
    w_pop = (r_count != '0);
    for (int i = 0; i < SNUM; i++) begin
      w_slot[i] = ptr;
      if (i_enq[i]) begin
        ptr = inc(ptr);
        n   = n + 1;
      end
    end
    w_tail_nxt  = ptr;
    w_count_nxt = CW'(int'(r_count) + n - (w_pop ? 1 : 0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= inc(r_head);
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // The popped head slot may be refilled in the same cycle; its old value is already out
  always_ff @(posedge clk) begin
    for (int i = 0; i < SNUM; i++) begin
      if (i_enq[i]) begin
        r_addr[w_slot[i]] <= i_addr[i];
        r_data[w_slot[i]] <= i_data[i];
      end
    end
  end

  assign o_valid = w_pop;
  assign o_addr  = r_addr[r_head];
  assign o_data  = r_data[r_head];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/preg_wb_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | preg_wb_sched : per-bank writeback queues feeding banked regfile ports    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module preg_wb_sched
  import preg_wb_sched_pkg::*;
#(
  parameter type T     = logic [63:0],
  parameter int  WNUM  = PKG_WNUM,
  parameter int  SNUM  = 4,
  parameter int  QLEN  = PKG_QLEN,
  parameter int  DEPTH = PKG_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [SNUM-1:0]                       src_valid,
  input  logic [SNUM-1:0][$clog2(QLEN)-1:0]     src_addr,
  input  logic [SNUM-1:0][$bits(T)-1:0]         src_data,
  output logic [SNUM-1:0]                       src_ready,
  output logic [WNUM-1:0]                       wvalid,
  output logic [WNUM-1:0][$clog2(QLEN)-1:0]     wa,
  output logic [WNUM-1:0][$bits(T)-1:0]         wdata,
  output logic                                  idle
);

  localparam int AW = $clog2(QLEN);
  localparam int DW = $bits(T);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WNUM-1:0][CW-1:0]   w_count;
  logic [WNUM-1:0][SNUM-1:0] w_enq;
  logic [SNUM-1:0]           w_accept;

  // Rank of source i in its bank counts itself unconditionally, so ready never depends on own valid
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < SNUM; i++) begin
      int rank;
      int free;
      rank = 1;
      for (int j = 0; j < i; j++) begin
        if (src_valid[j] && (bank(src_addr[j]) == bank(src_addr[i]))) rank = rank + 1;
      end
      free = DEPTH - int'(w_count[bank(src_addr[i])])
           + ((w_count[bank(src_addr[i])] != '0) ? 1 : 0);
      src_ready[i] = (rank <= free);
    end
  end

  assign w_accept = src_valid & src_ready;

  always_comb begin
    w_enq = '0;
    for (int b = 0; b < WNUM; b++) begin
      for (int i = 0; i < SNUM; i++) begin
        w_enq[b][i] = w_accept[i] && (bank(src_addr[i]) == bank_t'(b));
      end
    end
  end

  for (genvar b = 0; b < WNUM; b++) begin : g_bank
    wb_bank_fifo #(
      .SNUM  (SNUM),
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .CW    (CW)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_enq   (w_enq[b]),
      .i_addr  (src_addr),
      .i_data  (src_data),
      .o_valid (wvalid[b]),
      .o_addr  (wa[b]),
      .o_data  (wdata[b]),
      .o_count (w_count[b])
    );
  end

  assign idle = ~|wvalid;

endmodule
`default_nettype wire
